zint_multi: RTL



---
 rtl/zint_multi_pkg.sv | 24 ++
 rtl/zint_prienc.sv | 49 ++++
 rtl/zint_multi.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/zint_multi_pkg.sv
// Shared definitions for the multi-source Z80 interrupt controller: FSM states,
// /INT gap length and the IM2 vector composition helper.
package zint_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_VEC,
        ST_GAP
    } zint_state_e;

    localparam int unsigned IDX_W   = 3;
    localparam int unsigned GAP_LEN = 2;

    // Source index replaces bits [3:1] of the programmed base.
    function automatic logic [7:0] zint_vec(input logic [7:0] base,
                                            input logic [IDX_W-1:0] idx);
        logic [7:0] v;
        v      = base;
        v[3:1] = idx;
        return v;
    endfunction

endpackage

// File: rtl/zint_prienc.sv
// Pending-source priority encoder. Fixed priority (index 0 highest) by default;
// round-robin from a start pointer when ZINT_RRPRIO_EN is defined.
module zint_prienc
    import zint_multi_pkg::*;
#(
    parameter int unsigned NSRC = 4
) (
    input  logic [NSRC-1:0]  req,
`ifdef ZINT_RRPRIO_EN
    input  logic [IDX_W-1:0] start,
`endif
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] any_idx;
`ifdef ZINT_RRPRIO_EN
    logic [IDX_W-1:0] hi_idx;
    logic             hi_valid;
`endif

    always_comb begin
        any_idx = '0;
`ifdef ZINT_RRPRIO_EN
        hi_idx   = '0;
        hi_valid = 1'b0;
`endif
        // Descending scan so the lowest matching index wins.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_idx = IDX_W'(i);
            end
`ifdef ZINT_RRPRIO_EN
            if (req[i] && (i >= int'(start))) begin
                hi_idx   = IDX_W'(i);
                hi_valid = 1'b1;
            end
`endif
        end
        valid = |req;
`ifdef ZINT_RRPRIO_EN
        // Nothing at or above the pointer: wrap to the lowest set bit.
        idx = hi_valid ? hi_idx : any_idx;
`else
        idx = any_idx;
`endif
    end

endmodule

// File: rtl/zint_multi.sv
// Multi-source Z80 /INT generator with INTA detection and IM2 vector supply.
// Define ZINT_RRPRIO_EN for round-robin arbitration instead of fixed priority.
module zint_multi
    import zint_multi_pkg::*;
#(
    parameter int unsigned     NSRC    = 4,
    parameter int unsigned     INT_LEN = 32,
    parameter int unsigned     CNT_W   = 6,
    parameter logic [NSRC-1:0] AUTOCLR = 4'b0001
) (
    input  logic             fclk,
    input  logic             rst,
    input  logic [NSRC-1:0]  src_stb,
    input  logic [NSRC-1:0]  src_en,
    input  logic [7:0]       vec_base,
    input  logic             iorq_n,
    input  logic             m1_n,
    output logic             int_n,
    output logic [7:0]       vec_out,
    output logic             vec_ena,
    output logic [NSRC-1:0]  pending,
    output logic             ack_stb,
    output logic [IDX_W-1:0] ack_idx
);

    zint_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       gap_cnt_q;
    logic             iorq_s1_q, iorq_s_q, m1_s1_q, m1_s_q, inta_d_q;
    logic             inta, inta_rise;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             ack_fire, timeout;
    logic [NSRC-1:0]  clr;

`ifdef ZINT_RRPRIO_EN
    logic [IDX_W-1:0] rr_ptr_q;

    always_ff @(posedge fclk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (ack_fire) begin
            rr_ptr_q <= (win_idx == IDX_W'(NSRC - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    zint_prienc #(
        .NSRC (NSRC)
    ) u_prienc (
        .req   (pending),
`ifdef ZINT_RRPRIO_EN
        .start (rr_ptr_q),
`endif
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign inta      = ~iorq_s_q & ~m1_s_q;
    assign inta_rise = inta & ~inta_d_q;

    always_comb begin
        ack_fire = (state_q == ST_ASSERT) && inta_rise && win_valid;
        timeout  = (state_q == ST_ASSERT) && !ack_fire && (cnt_q == CNT_W'(INT_LEN - 1));
        clr      = '0;
        if (ack_fire) begin
            clr = NSRC'(1) << win_idx;
        end else if (timeout) begin
            clr = AUTOCLR;
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gap_cnt_q <= '0;
            iorq_s1_q <= 1'b1;
            iorq_s_q  <= 1'b1;
            m1_s1_q   <= 1'b1;
            m1_s_q    <= 1'b1;
            inta_d_q  <= 1'b0;
            int_n     <= 1'b1;
            vec_out   <= '0;
            vec_ena   <= 1'b0;
            pending   <= '0;
            ack_stb   <= 1'b0;
            ack_idx   <= '0;
        end else begin
            iorq_s1_q <= iorq_n;
            iorq_s_q  <= iorq_s1_q;
            m1_s1_q   <= m1_n;
            m1_s_q    <= m1_s1_q;
            inta_d_q  <= inta;
            // New requests take precedence over a same-cycle clear.
            pending   <= (pending & ~clr) | (src_stb & src_en);
            ack_stb   <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (|pending) begin
                        state_q <= ST_ASSERT;
                        int_n   <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (ack_fire) begin
                        ack_idx <= win_idx;
                        vec_out <= zint_vec(vec_base, win_idx);
                        ack_stb <= 1'b1;
                        vec_ena <= 1'b1;
                        int_n   <= 1'b1;
                        state_q <= ST_VEC;
                    end else if (timeout) begin
                        int_n     <= 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= ST_GAP;
                    end
                end
                ST_VEC: begin
                    if (!inta) begin
                        vec_ena   <= 1'b0;
                        gap_cnt_q <= '0;
                        state_q   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    gap_cnt_q <= gap_cnt_q + 1'b1;
                    // Last gap cycle makes the idle decision itself so /INT is
                    // high for exactly GAP_LEN cycles before re-asserting.
                    if (gap_cnt_q == 2'(GAP_LEN - 1)) begin
                        cnt_q <= '0;
                        if (|pending) begin
                            int_n   <= 1'b0;
                            state_q <= ST_ASSERT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
